// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use and branch-in-decode hazard detection.
// Feeds the forwarding unit with the EX-stage register addresses and write
// controls, holds/flushes the front end on hazards, and counts the cycles a
// bubble is inserted into EX because of a hazard.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // decode-stage instruction
    input  logic              validD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        r3_addrD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              BranchD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [DATA_W-1:0] rd1D,
    input  logic [DATA_W-1:0] rd2D,
    input  logic [DATA_W-1:0] immD,
    // memory-stage producer
    input  logic [4:0]        r3_addrM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    // external control
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr,
    // execute-stage register
    output logic              validE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        r3_addrE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [DATA_W-1:0] rd1E,
    output logic [DATA_W-1:0] rd2E,
    output logic [DATA_W-1:0] immE,
    // hazard control
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        r3;
        logic              reg_write;
        logic              mem_to_reg;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ex_t        e_q;
    ex_t        d_in;
    logic       hit_e;
    logic       hit_m;
    logic       lwstall;
    logic       branchstall;
    logic       hz;
    logic       bubble_adv;

    // Pack the decode-stage fields into the EX register image.
    always_comb begin
        d_in            = '0;
        d_in.valid      = validD;
        d_in.rs         = rsD;
        d_in.rt         = rtD;
        d_in.r3         = r3_addrD;
        d_in.reg_write  = RegWriteD;
        d_in.mem_to_reg = MemtoRegD;
        d_in.ctrl       = ctrlD;
        d_in.rd1        = rd1D;
        d_in.rd2        = rd2D;
        d_in.imm        = immD;
    end

    // Dependency of the decode instruction on the EX and MEM producers.
    // $0 is hardwired, so writing it never creates a dependency.
    always_comb begin
        hit_e = e_q.valid & e_q.reg_write & (e_q.r3 != 5'd0) &
                ((e_q.r3 == rsD) | (e_q.r3 == rtD));
        hit_m = RegWriteM & MemtoRegM & (r3_addrM != 5'd0) &
                ((r3_addrM == rsD) | (r3_addrM == rtD));
    end

    // Load-use needs one bubble; a decode-resolved branch also waits for an
    // ALU result in EX, and for a load result until it leaves MEM.
    always_comb begin
        lwstall     = validD & e_q.mem_to_reg & hit_e;
        branchstall = validD & BranchD & (hit_e | hit_m);
        hz          = lwstall | branchstall;
        bubble_adv  = hz & ~stall_i & ~flush_i;
    end

    assign stallF = hz | stall_i;
    assign stallD = hz | stall_i;
    assign flushE = bubble_adv;

    // EX register: external flush beats external hold, which beats a hazard bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        e_q <= '0;
        else if (flush_i)  e_q <= '0;
        else if (stall_i)  e_q <= e_q;
        else if (hz)       e_q <= '0;
        else               e_q <= d_in;
    end

    // Hazard-bubble cycle counter, saturating, with synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             stall_cnt <= '0;
        else if (cnt_clr)                       stall_cnt <= '0;
        else if (bubble_adv && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
    end

    assign validE    = e_q.valid;
    assign rsE       = e_q.rs;
    assign rtE       = e_q.rt;
    assign r3_addrE  = e_q.r3;
    assign RegWriteE = e_q.reg_write;
    assign MemtoRegE = e_q.mem_to_reg;
    assign ctrlE     = e_q.ctrl;
    assign rd1E      = e_q.rd1;
    assign rd2E      = e_q.rd2;
    assign immE      = e_q.imm;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed vector table, hand sequences for the
// counter and async reset, then random traffic against a reference model.
module tb_id_ex_hazard_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validD, RegWriteD, MemtoRegD, BranchD;
    logic [4:0]  rsD, rtD, r3_addrD, r3_addrM;
    logic        RegWriteM, MemtoRegM, stall_i, flush_i, cnt_clr;
    logic [7:0]  ctrlD;
    logic [31:0] rd1D, rd2D, immD;

    logic        validE, RegWriteE, MemtoRegE, stallF, stallD, flushE;
    logic [4:0]  rsE, rtE, r3_addrE;
    logic [7:0]  ctrlE;
    logic [31:0] rd1E, rd2E, immE;
    logic [15:0] stall_cnt;

    logic        validE2, RegWriteE2, MemtoRegE2, stallF2, stallD2, flushE2;
    logic [4:0]  rsE2, rtE2, r3_addrE2;
    logic [7:0]  ctrlE2;
    logic [31:0] rd1E2, rd2E2, immE2;
    logic [2:0]  stall_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .validD(validD), .rsD(rsD), .rtD(rtD),
        .r3_addrD(r3_addrD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .BranchD(BranchD), .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD),
        .r3_addrM(r3_addrM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .stall_i(stall_i), .flush_i(flush_i), .cnt_clr(cnt_clr),
        .validE(validE), .rsE(rsE), .rtE(rtE), .r3_addrE(r3_addrE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .ctrlE(ctrlE),
        .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .validD(validD), .rsD(rsD), .rtD(rtD),
        .r3_addrD(r3_addrD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .BranchD(BranchD), .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD),
        .r3_addrM(r3_addrM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .stall_i(stall_i), .flush_i(flush_i), .cnt_clr(cnt_clr),
        .validE(validE2), .rsE(rsE2), .rtE(rtE2), .r3_addrE(r3_addrE2),
        .RegWriteE(RegWriteE2), .MemtoRegE(MemtoRegE2), .ctrlE(ctrlE2),
        .rd1E(rd1E2), .rd2E(rd2E2), .immE(immE2),
        .stallF(stallF2), .stallD(stallD2), .flushE(flushE2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        int v, rs, rt, r3, rw, mtr, br;
        int r3m, rwm, mtrm, st, fl;
        int x_stall, x_flush, x_ve, x_rd1, x_cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int v, input int rs, input int rt, input int r3,
                         input int rw, input int mtr, input int br,
                         input int r3m, input int rwm, input int mtrm,
                         input int st, input int fl, input int clr, input int tag);
        validD = 1'(v); rsD = 5'(rs); rtD = 5'(rt); r3_addrD = 5'(r3);
        RegWriteD = 1'(rw); MemtoRegD = 1'(mtr); BranchD = 1'(br);
        r3_addrM = 5'(r3m); RegWriteM = 1'(rwm); MemtoRegM = 1'(mtrm);
        stall_i = 1'(st); flush_i = 1'(fl); cnt_clr = 1'(clr);
        ctrlD = 8'(tag); rd1D = 32'h1000 + 32'(tag);
        rd2D = 32'h2000 + 32'(tag); immD = 32'h3000 + 32'(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: contents of EX as the rules define it.
    int m_v, m_rs, m_rt, m_r3, m_rw, m_mtr, m_ctrl;
    logic [31:0] m_rd1, m_rd2, m_imm;
    int m_cnt, m_cnt2;

    function automatic bit reads(input int r);
        return (r != 0) && (r == int'(rsD) || r == int'(rtD));
    endfunction

    initial begin
        tbl[0]  = '{1,1,0,2,1,1,0, 0,0,0, 0,0, 0,0,1,'h1000,0};
        tbl[1]  = '{1,2,4,3,1,0,0, 0,0,0, 0,0, 1,1,0,0,1};
        tbl[2]  = '{1,2,4,3,1,0,0, 0,0,0, 0,0, 0,0,1,'h1002,1};
        tbl[3]  = '{1,3,0,0,0,0,1, 0,0,0, 0,0, 1,1,0,0,2};
        tbl[4]  = '{1,3,0,0,0,0,1, 3,1,0, 0,0, 0,0,1,'h1004,2};
        tbl[5]  = '{1,1,0,5,1,1,0, 0,0,0, 0,0, 0,0,1,'h1005,2};
        tbl[6]  = '{1,5,0,0,0,0,1, 0,0,0, 0,0, 1,1,0,0,3};
        tbl[7]  = '{1,5,0,0,0,0,1, 5,1,1, 0,0, 1,1,0,0,4};
        tbl[8]  = '{1,5,0,0,0,0,1, 0,0,0, 0,0, 0,0,1,'h1008,4};
        tbl[9]  = '{1,1,0,0,1,1,0, 0,0,0, 0,0, 0,0,1,'h1009,4};
        tbl[10] = '{1,0,0,6,1,0,0, 0,0,0, 0,0, 0,0,1,'h100A,4};
        tbl[11] = '{1,1,0,7,1,1,0, 0,0,0, 0,0, 0,0,1,'h100B,4};
        tbl[12] = '{0,7,7,8,1,0,0, 0,0,0, 0,0, 0,0,0,'h100C,4};
        tbl[13] = '{1,1,0,9,1,1,0, 0,0,0, 0,0, 0,0,1,'h100D,4};
        tbl[14] = '{1,9,0,10,1,0,0, 0,0,0, 1,0, 1,0,1,'h100D,4};
        tbl[15] = '{1,9,0,10,1,0,0, 0,0,0, 1,1, 1,0,0,0,4};
        tbl[16] = '{1,9,0,10,1,0,0, 0,0,0, 0,0, 0,0,1,'h1010,4};

        // reset state
        rst_n = 1'b0;
        drive(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0);
        #12;
        chk("rst_validE", validE, 0);
        chk("rst_rd1E", rd1E, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stallF", stallF, 0);
        chk("rst_flushE", flushE, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed vector table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].r3, tbl[i].rw, tbl[i].mtr,
                  tbl[i].br, tbl[i].r3m, tbl[i].rwm, tbl[i].mtrm, tbl[i].st,
                  tbl[i].fl, 0, i);
            #3;
            chk($sformatf("v%0d_stallF", i), stallF, tbl[i].x_stall);
            chk($sformatf("v%0d_stallD", i), stallD, tbl[i].x_stall);
            chk($sformatf("v%0d_flushE", i), flushE, tbl[i].x_flush);
            tick();
            chk($sformatf("v%0d_validE", i), validE, tbl[i].x_ve);
            chk($sformatf("v%0d_rd1E", i), rd1E, tbl[i].x_rd1);
            chk($sformatf("v%0d_cnt", i), stall_cnt, tbl[i].x_cnt);
        end

        // counter clear, then saturation of the narrow copy
        drive(0,0,0,0,0,0,0, 0,0,0, 0,0,1, 0);
        tick();
        chk("clr_cnt", stall_cnt, 0);
        chk("clr_cnt2", stall_cnt2, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1,3,0,0,0,0,1, 3,1,1, 0,0,0, 40 + k);
            tick();
        end
        chk("sat_cnt", stall_cnt, 10);
        chk("sat_cnt2", stall_cnt2, 7);
        chk("sat_validE", validE, 0);
        drive(1,3,0,0,0,0,1, 3,1,1, 0,0,1, 60);
        #3;
        chk("clr_hz_flushE", flushE, 1);
        tick();
        chk("clr_hz_cnt", stall_cnt, 0);
        chk("clr_hz_cnt2", stall_cnt2, 0);

        // async reset in the middle of a load-use stall
        drive(1,1,0,2,1,1,0, 0,0,0, 0,0,0, 70);
        tick();
        drive(1,2,4,3,1,0,0, 0,0,0, 0,0,0, 71);
        #2;
        chk("ar_pre_stallF", stallF, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_validE", validE, 0);
        chk("ar_stallF", stallF, 0);
        chk("ar_flushE", flushE, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_restart_validE", validE, 1);
        chk("ar_restart_rd1E", rd1E, 32'h1047);
        chk("ar_restart_cnt", stall_cnt, 0);

        // random traffic against the reference model, from a fresh reset
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        m_v = 0; m_rs = 0; m_rt = 0; m_r3 = 0; m_rw = 0; m_mtr = 0; m_ctrl = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_cnt = 0; m_cnt2 = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            bit ld_e, dep_e, dep_m, lw_hz, br_hz, hz, bub;
            validD    = ($urandom_range(0, 9) < 8);
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            r3_addrD  = 5'($urandom_range(0, 3));
            RegWriteD = 1'($urandom_range(0, 1));
            MemtoRegD = ($urandom_range(0, 2) == 0);
            BranchD   = ($urandom_range(0, 3) == 0);
            ctrlD     = 8'($urandom);
            rd1D      = $urandom;
            rd2D      = $urandom;
            immD      = $urandom;
            r3_addrM  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1));
            MemtoRegM = 1'($urandom_range(0, 1));
            stall_i   = ($urandom_range(0, 9) == 0);
            flush_i   = ($urandom_range(0, 9) == 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            #3;
            dep_e = (m_v != 0) && (m_rw != 0) && reads(m_r3);
            dep_m = RegWriteM && MemtoRegM && reads(int'(r3_addrM));
            ld_e  = (m_mtr != 0);
            lw_hz = validD && ld_e && dep_e;
            br_hz = validD && BranchD && (dep_e || dep_m);
            hz    = lw_hz || br_hz;
            bub   = hz && !stall_i && !flush_i;
            chk("rnd_stallF", stallF, hz || stall_i);
            chk("rnd_stallD", stallD, hz || stall_i);
            chk("rnd_flushE", flushE, bub);
            if (flush_i || (!stall_i && hz)) begin
                m_v = 0; m_rs = 0; m_rt = 0; m_r3 = 0; m_rw = 0; m_mtr = 0;
                m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            end else if (!stall_i) begin
                m_v = validD; m_rs = rsD; m_rt = rtD; m_r3 = r3_addrD;
                m_rw = RegWriteD; m_mtr = MemtoRegD; m_ctrl = ctrlD;
                m_rd1 = rd1D; m_rd2 = rd2D; m_imm = immD;
            end
            if (cnt_clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (bub) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt2 = (m_cnt2 < 7)     ? m_cnt2 + 1 : m_cnt2;
            end
            tick();
            chk("rnd_validE", validE, m_v);
            chk("rnd_rsE", rsE, m_rs);
            chk("rnd_rtE", rtE, m_rt);
            chk("rnd_r3E", r3_addrE, m_r3);
            chk("rnd_RegWriteE", RegWriteE, m_rw);
            chk("rnd_MemtoRegE", MemtoRegE, m_mtr);
            chk("rnd_ctrlE", ctrlE, m_ctrl);
            chk("rnd_rd1E", rd1E, m_rd1);
            chk("rnd_rd2E", rd2E, m_rd2);
            chk("rnd_immE", immE, m_imm);
            chk("rnd_cnt", stall_cnt, m_cnt);
            chk("rnd_cnt2", stall_cnt2, m_cnt2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
